// File: rtl/mem_access_pkg.sv
// Shared types for the MAR/MDR memory-access unit: transfer sizes, FSM states,
// lane counts and the request legality check.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int LANES_W32 = 4;
    localparam int LANES_W64 = 8;

    // Misaligned accesses, and dwords on a 32-bit bus, never reach memory.
    function automatic logic req_is_bad(input size_e size, input logic [2:0] addr_lo,
                                        input logic dword_ok);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo[1:0];
            default: return !dword_ok || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: places store data and byte enables on the bus and
// extracts/extends load data. Bus byte i (bits 8i+7:8i) sits at offset NB-1-i.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_e                         i_size,
    input  logic                          i_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]   i_offset,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [DATA_W-1:0]             i_rdata,
    output logic [DATA_W-1:0]             o_wdata,
    output logic [DATA_W/8-1:0]           o_be,
    output logic [DATA_W-1:0]             o_rdata
);
    localparam int NB = DATA_W / 8;

    logic [7:0]        w_nbytes;
    logic [7:0]        w_lsb_lane;
    logic [NB-1:0]     w_lanes;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_load;
    logic              w_sign;

    always_comb begin
        w_nbytes   = 8'd1 << i_size;
        // Lowest bus byte occupied by the item; wraps for illegal sizes, which shifts everything out.
        w_lsb_lane = 8'(NB) - 8'(i_offset) - w_nbytes;
        w_lanes    = '0;
        w_mask     = '0;
        for (int b = 0; b < NB; b++) begin
            w_lanes[b]       = (8'(b) < w_nbytes);
            w_mask[8*b +: 8] = {8{w_lanes[b]}};
        end
        o_be    = w_lanes << w_lsb_lane;
        o_wdata = (i_wdata & w_mask) << {w_lsb_lane, 3'b000};
        w_load  = (i_rdata >> {w_lsb_lane, 3'b000}) & w_mask;
        case (i_size)
            SZ_BYTE: w_sign = w_load[7];
            SZ_HALF: w_sign = w_load[15];
            SZ_WORD: w_sign = w_load[31];
            default: w_sign = w_load[DATA_W-1];
        endcase
        o_rdata = w_load | ((w_sign && !i_unsigned) ? ~w_mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access engine with enable/MOC four-phase handshake.
// Optional WAIT timeout enabled by defining MEM_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready when MOC low; latches MAR/MDR/byte enables on accept
// ST_WAIT | mem_enable high until MOC (or timeout when enabled)
// ST_RESP | one-cycle rsp_valid pulse, then back to idle
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_rw,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    output logic                o_rsp_valid,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic                o_mem_enable,
    output logic                o_mem_rw,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_moc
);
    localparam int NB    = (DATA_W == 64) ? LANES_W64 : LANES_W32;
    localparam int OFF_W = $clog2(NB);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("mem_access_unit: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYC must be at least 1");
    end

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_mdr;
    logic [NB-1:0]       r_be;
    logic                r_rw;
    size_e               r_size;
    logic                r_unsigned;
    logic                r_mem_enable;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
`ifdef MEM_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0]    r_timer;
`endif

    logic                w_req_ready;
    logic                w_accept;
    logic                w_bad;
    size_e               w_size;
    logic                w_unsigned;
    logic [OFF_W-1:0]    w_offset;
    logic [DATA_W-1:0]   w_wdata_placed;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_rdata_ext;

    assign w_req_ready = (r_state == ST_IDLE) && !i_mem_moc;
    assign w_accept    = i_req_valid && w_req_ready;
    assign w_bad       = req_is_bad(size_e'(i_req_size), i_req_addr[2:0], NB == LANES_W64);

    // One aligner serves both directions: request fields in IDLE, latched fields afterwards.
    assign w_size     = (r_state == ST_IDLE) ? size_e'(i_req_size) : r_size;
    assign w_unsigned = (r_state == ST_IDLE) ? i_req_unsigned : r_unsigned;
    assign w_offset   = (r_state == ST_IDLE) ? i_req_addr[OFF_W-1:0] : r_addr[OFF_W-1:0];

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_size     (w_size),
        .i_unsigned (w_unsigned),
        .i_offset   (w_offset),
        .i_wdata    (i_req_wdata),
        .i_rdata    (i_mem_rdata),
        .o_wdata    (w_wdata_placed),
        .o_be       (w_be),
        .o_rdata    (w_rdata_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_mdr        <= '0;
            r_be         <= '0;
            r_rw         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_unsigned   <= 1'b0;
            r_mem_enable <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
`ifdef MEM_TIMEOUT_EN
            r_timer      <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rsp_rdata <= '0;
                    if (w_accept) begin
                        r_addr     <= i_req_addr;
                        r_mdr      <= w_wdata_placed;
                        r_be       <= w_be;
                        r_rw       <= i_req_rw;
                        r_size     <= size_e'(i_req_size);
                        r_unsigned <= i_req_unsigned;
                        if (w_bad) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state      <= ST_WAIT;
                            r_mem_enable <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                            r_timer      <= TMR_W'(TIMEOUT_CYC - 1);
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_mem_moc) begin
                        r_state      <= ST_RESP;
                        r_mem_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= r_rw ? w_rdata_ext : '0;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_timer == '0) begin
                        r_state      <= ST_RESP;
                        r_mem_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
`endif
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready  = w_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_err    = r_rsp_err;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_mdr;
    assign o_mem_be     = r_be;
    assign o_mem_enable = r_mem_enable;
    assign o_mem_rw     = r_rw;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32) with a response scoreboard and a
// small memory responder; the timeout scenario follows MEM_TIMEOUT_EN.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_rdata;
    logic        mem_moc;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_rw       (req_rw),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_be       (mem_be),
        .o_mem_enable   (mem_enable),
        .o_mem_rw       (mem_rw),
        .i_mem_rdata    (mem_rdata),
        .i_mem_moc      (mem_moc)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    // responder controls, written only by the main sequence
    bit          mem_mute = 0;
    bit          mem_force = 0;
    int          mem_k = 0;
    logic [31:0] mem_word = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: raises MOC mem_k cycles after it first sees enable, drops it once enable falls.
    initial begin
        int en_cnt;
        en_cnt    = 0;
        mem_moc   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_force) begin
                mem_moc = 1'b1;
            end else if (mem_mute) begin
                mem_moc = 1'b0;
                en_cnt  = 0;
            end else if (mem_enable && !mem_moc) begin
                if (en_cnt == mem_k) begin
                    mem_moc   = 1'b1;
                    mem_rdata = mem_word;
                end else begin
                    en_cnt++;
                end
            end else if (!mem_enable) begin
                mem_moc = 1'b0;
                en_cnt  = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input string tag, input bit push);
        exp_t e;
        @(negedge clk);
        req_rw       = rw;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        acc_cyc = cyc;
        if (push) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.lat   = exp_lat;
            e.tag   = tag;
            sb.push_back(e);
        end
        @(negedge clk);
        // scramble the request bus: the unit must only use what it latched
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        req_rw    = ~rw;
    endtask

    task automatic wait_rsp(input int budget);
        exp_t e;
        bit   seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(seen), 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({e.tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            chk({e.tag, "_err"}, 64'(rsp_err), 64'(e.err));
            if (e.lat >= 0) chk({e.tag, "_lat"}, 64'(cyc - acc_cyc), 64'(e.lat));
            @(negedge clk);
            chk({e.tag, "_pulse"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic rw);
        chk({tag, "_en"}, 64'(mem_enable), 64'd1);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(addr));
        chk({tag, "_be"}, 64'(mem_be), 64'(be));
        chk({tag, "_rw"}, 64'(mem_rw), 64'(rw));
        if (!rw) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wd));
    endtask

    initial begin
        bit seen_rsp;
        bit saw_low;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_rw       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_enable", 64'(mem_enable), 64'd0);
        chk("rst_be", 64'(mem_be), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        reset = 1'b0;

        // word load, MOC two cycles after enable
        mem_k = 2; mem_word = 32'hDEADBEEF;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4, "lw", 1);
        chk_bus("lw", 32'h10, 32'h0, 4'b1111, 1'b1);
        wait_rsp(20);

        mem_k = 1; mem_word = 32'h11223380;
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3, "lb", 1);
        chk_bus("lb", 32'h13, 32'h0, 4'b0001, 1'b1);
        wait_rsp(20);
        issue(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, "lbu", 1);
        wait_rsp(20);

        mem_k = 0; mem_word = 32'h80011234;
        issue(1'b1, 2'b01, 1'b0, 32'h20, 32'h0, 32'hFFFF8001, 1'b0, 2, "lh", 1);
        chk_bus("lh", 32'h20, 32'h0, 4'b1100, 1'b1);
        wait_rsp(20);
        mem_word = 32'h1234F00D;
        issue(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000F00D, 1'b0, 2, "lhu", 1);
        wait_rsp(20);

        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 1'b0, 2, "sh", 1);
        chk_bus("sh", 32'h22, 32'h0000ABCD, 4'b0011, 1'b0);
        wait_rsp(20);
        issue(1'b0, 2'b00, 1'b0, 32'h40, 32'h0000005A, 32'h0, 1'b0, 2, "sb", 1);
        chk_bus("sb", 32'h40, 32'h5A000000, 4'b1000, 1'b0);
        wait_rsp(20);
        mem_k = 3;
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 5, "sw", 1);
        chk_bus("sw", 32'h30, 32'hCAFEF00D, 4'b1111, 1'b0);
        wait_rsp(20);

        // errors never touch memory
        issue(1'b1, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, "lw_mis", 1);
        chk("lw_mis_en1", 64'(mem_enable), 64'd0);
        wait_rsp(5);
        chk("lw_mis_en2", 64'(mem_enable), 64'd0);
        issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h1234, 32'h0, 1'b1, 1, "sh_mis", 1);
        wait_rsp(5);
        issue(1'b1, 2'b11, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1, 1, "ld_w32", 1);
        chk("ld_w32_en", 64'(mem_enable), 64'd0);
        wait_rsp(5);

`ifdef MEM_TIMEOUT_EN
        mem_mute = 1;
        issue(1'b1, 2'b10, 1'b0, 32'h50, 32'h0, 32'h0, 1'b1, 17, "tmo", 1);
        wait_rsp(30);
        chk("tmo_en", 64'(mem_enable), 64'd0);
        chk("tmo_ready", 64'(req_ready), 64'd1);
        mem_force = 1;
        seen_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            seen_rsp |= rsp_valid;
        end
        chk("tmo_late_moc_rsp", 64'(seen_rsp), 64'd0);
        chk("tmo_late_moc_ready", 64'(req_ready), 64'd0);
        mem_force = 0;
        mem_mute  = 0;
        repeat (2) @(negedge clk);
        chk("tmo_ready_after", 64'(req_ready), 64'd1);
`else
        mem_mute = 1;
        issue(1'b1, 2'b10, 1'b0, 32'h50, 32'h0, 32'h01234567, 1'b0, -1, "nowait", 1);
        seen_rsp = 0;
        saw_low  = 0;
        repeat (40) begin
            @(negedge clk);
            seen_rsp |= rsp_valid;
            saw_low  |= !mem_enable;
        end
        chk("nowait_rsp", 64'(seen_rsp), 64'd0);
        chk("nowait_en_low", 64'(saw_low), 64'd0);
        mem_k = 0; mem_word = 32'h01234567; mem_mute = 0;
        wait_rsp(10);
`endif

        // reset while waiting, with MOC arriving and held high
        mem_mute = 1;
        issue(1'b1, 2'b10, 1'b0, 32'h60, 32'h0, 32'h0, 1'b0, 0, "rst_wait", 0);
        @(negedge clk);
        chk("rst_wait_en_before", 64'(mem_enable), 64'd1);
        mem_force = 1;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wait_en", 64'(mem_enable), 64'd0);
        chk("rst_wait_ready", 64'(req_ready), 64'd0);
        seen_rsp = 0;
        saw_low  = 0;
        repeat (3) begin
            @(negedge clk);
            seen_rsp |= rsp_valid;
            saw_low  |= req_ready;
        end
        chk("rst_wait_no_rsp", 64'(seen_rsp), 64'd0);
        chk("rst_wait_ready_held", 64'(saw_low), 64'd0);
        mem_force = 0;
        mem_mute  = 0;
        repeat (2) @(negedge clk);
        chk("rst_wait_ready_after", 64'(req_ready), 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
